// File: rtl/ps_gpio_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ps_gpio_bridge_pkg
// Shared definitions for the PS/MCU GPIO pad bridge.
//   OWNER_MCU / OWNER_PS : per-pin ownership encoding held in the owner register
//   DEFAULT_SYNC_STAGES  : default input synchroniser depth
//   DEFAULT_DEB_W        : default debounce counter / threshold width
//   deb_cnt_t            : debounce counter type at the default width
// ---------------------------------------------------------------------------
package ps_gpio_bridge_pkg;

   localparam logic OWNER_MCU = 1'b0;
   localparam logic OWNER_PS  = 1'b1;

   localparam int DEFAULT_SYNC_STAGES = 2;
   localparam int DEFAULT_DEB_W       = 8;

   typedef logic [DEFAULT_DEB_W-1:0] deb_cnt_t;

endpackage

// File: rtl/gpio_in_filter.sv
// ---------------------------------------------------------------------------
// gpio_in_filter
// One pad input channel: synchroniser, debounce filter and edge detector.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   pad_i        : raw asynchronous pad input
//   thresh_i     : debounce threshold in cycles (0 and 1 both mean no filtering)
//   rise_en_i    : rising-edge report enable
//   fall_en_i    : falling-edge report enable
//   f_o          : filtered input level
//   rise_o       : one-cycle pulse on an enabled rising edge of f_o
//   fall_o       : one-cycle pulse on an enabled falling edge of f_o
// ---------------------------------------------------------------------------
module gpio_in_filter
   import ps_gpio_bridge_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int DEB_W       = DEFAULT_DEB_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pad_i,
   input  logic [DEB_W-1:0] thresh_i,
   input  logic             rise_en_i,
   input  logic             fall_en_i,
   output logic             f_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_filt;
   logic                   r_filt_d;
   logic [DEB_W-1:0]       r_cnt;

   logic                   w_s;
   logic [DEB_W:0]         w_cnt_inc;

   assign w_s = r_sync[SYNC_STAGES-1];

   // One extra bit so c+1 is compared against the threshold without wrapping.
   assign w_cnt_inc = {1'b0, r_cnt} + {{DEB_W{1'b0}}, 1'b1};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync   <= '0;
         r_filt   <= 1'b0;
         r_filt_d <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], pad_i};
         r_filt_d <= r_filt;
         if (w_s == r_filt) begin
            // Any return to the filtered level restarts the stability count.
            r_cnt <= '0;
         end else if (w_cnt_inc >= {1'b0, thresh_i}) begin
            r_filt <= w_s;
            r_cnt  <= '0;
         end else begin
            r_cnt <= w_cnt_inc[DEB_W-1:0];
         end
      end
   end

   assign f_o    = r_filt;
   assign rise_o = r_filt & ~r_filt_d & rise_en_i;
   assign fall_o = ~r_filt & r_filt_d & fall_en_i;

endmodule

// File: rtl/ps_gpio_pad_bridge.sv
// ---------------------------------------------------------------------------
// ps_gpio_pad_bridge
// Per-pin ownership bridge between the PS EMIO GPIO bank and MCU pads.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   ps_sel_i              : per-pin owner request (1 = PS, 0 = MCU)
//   ps_out_i / ps_oe_i    : PS drive value / enable
//   mcu_out_i / mcu_oe_i  : MCU drive value / enable
//   pad_in_i              : raw asynchronous pad inputs
//   pad_out_o / pad_oe_o  : registered pad drive value / enable
//   ps_in_o / mcu_in_o    : filtered pad inputs (identical, owner independent)
//   deb_thresh_i          : global debounce threshold in cycles
//   rise_en_i / fall_en_i : per-pin edge interrupt enables
//   irq_clr_i             : write-1 clear of pending flags
//   irq_pending_o         : sticky per-pin pending flags
//   irq_o                 : registered OR of the pending flags
// ---------------------------------------------------------------------------
module ps_gpio_pad_bridge
   import ps_gpio_bridge_pkg::*;
#(
   parameter int NUM_PINS    = 32,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int DEB_W       = DEFAULT_DEB_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_PINS-1:0] ps_sel_i,
   input  logic [NUM_PINS-1:0] ps_out_i,
   input  logic [NUM_PINS-1:0] ps_oe_i,
   output logic [NUM_PINS-1:0] ps_in_o,
   input  logic [NUM_PINS-1:0] mcu_out_i,
   input  logic [NUM_PINS-1:0] mcu_oe_i,
   output logic [NUM_PINS-1:0] mcu_in_o,
   input  logic [NUM_PINS-1:0] pad_in_i,
   output logic [NUM_PINS-1:0] pad_out_o,
   output logic [NUM_PINS-1:0] pad_oe_o,
   input  logic [DEB_W-1:0]    deb_thresh_i,
   input  logic [NUM_PINS-1:0] rise_en_i,
   input  logic [NUM_PINS-1:0] fall_en_i,
   input  logic [NUM_PINS-1:0] irq_clr_i,
   output logic [NUM_PINS-1:0] irq_pending_o,
   output logic                irq_o
);

   logic [NUM_PINS-1:0] r_sel;
   logic [NUM_PINS-1:0] r_pad_out;
   logic [NUM_PINS-1:0] r_pad_oe;
   logic [NUM_PINS-1:0] r_pending;
   logic                r_irq;

   logic [NUM_PINS-1:0] w_turn;
   logic [NUM_PINS-1:0] w_drv_out;
   logic [NUM_PINS-1:0] w_drv_oe;
   logic [NUM_PINS-1:0] w_filt;
   logic [NUM_PINS-1:0] w_rise;
   logic [NUM_PINS-1:0] w_fall;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
         gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
         ) u_filt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .pad_i     (pad_in_i[gi]),
            .thresh_i  (deb_thresh_i),
            .rise_en_i (rise_en_i[gi]),
            .fall_en_i (fall_en_i[gi]),
            .f_o       (w_filt[gi]),
            .rise_o    (w_rise[gi]),
            .fall_o    (w_fall[gi])
         );

         // Drive selection uses the registered owner, never the raw request.
         assign w_drv_out[gi] = (r_sel[gi] == OWNER_PS) ? ps_out_i[gi] : mcu_out_i[gi];
         assign w_drv_oe[gi]  = (r_sel[gi] == OWNER_PS) ? ps_oe_i[gi]  : mcu_oe_i[gi];
      end
   endgenerate

   // A pin whose request differs from its registered owner is handing over.
   assign w_turn = ps_sel_i ^ r_sel;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sel     <= {NUM_PINS{OWNER_MCU}};
         r_pad_out <= '0;
         r_pad_oe  <= '0;
         r_pending <= '0;
         r_irq     <= 1'b0;
      end else begin
         // Turnaround blanks the pin for one cycle while the owner updates;
         // pins not in turnaround already have r_sel == ps_sel_i.
         r_sel     <= ps_sel_i;
         r_pad_out <= w_drv_out & ~w_turn;
         r_pad_oe  <= w_drv_oe & ~w_turn;
         // A new edge wins over a clear in the same cycle.
         r_pending <= (r_pending & ~irq_clr_i) | w_rise | w_fall;
         r_irq     <= |r_pending;
      end
   end

   assign pad_out_o     = r_pad_out;
   assign pad_oe_o      = r_pad_oe;
   assign ps_in_o       = w_filt;
   assign mcu_in_o      = w_filt;
   assign irq_pending_o = r_pending;
   assign irq_o         = r_irq;

endmodule

// File: tb/tb_ps_gpio_pad_bridge.sv
// ---------------------------------------------------------------------------
// tb_ps_gpio_pad_bridge
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the pad bridge kept in this bench.
// ---------------------------------------------------------------------------
module tb_ps_gpio_pad_bridge;
   import ps_gpio_bridge_pkg::*;

   localparam int NP = 32;
   localparam int SS = DEFAULT_SYNC_STAGES;
   localparam int DW = DEFAULT_DEB_W;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [NP-1:0] ps_sel_i, ps_out_i, ps_oe_i, mcu_out_i, mcu_oe_i, pad_in_i;
   logic [NP-1:0] rise_en_i, fall_en_i, irq_clr_i;
   deb_cnt_t      deb_thresh_i;
   logic [NP-1:0] ps_in_o, mcu_in_o, pad_out_o, pad_oe_o, irq_pending_o;
   logic          irq_o;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   logic [NP-1:0] m_sel, m_out, m_oe, m_f, m_fd, m_pend;
   logic          m_irq;
   logic [NP-1:0] m_hist [SS];
   int            m_run  [NP];

   ps_gpio_pad_bridge #(
      .NUM_PINS    (NP),
      .SYNC_STAGES (SS),
      .DEB_W       (DW)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ps_sel_i      (ps_sel_i),
      .ps_out_i      (ps_out_i),
      .ps_oe_i       (ps_oe_i),
      .ps_in_o       (ps_in_o),
      .mcu_out_i     (mcu_out_i),
      .mcu_oe_i      (mcu_oe_i),
      .mcu_in_o      (mcu_in_o),
      .pad_in_i      (pad_in_i),
      .pad_out_o     (pad_out_o),
      .pad_oe_o      (pad_oe_o),
      .deb_thresh_i  (deb_thresh_i),
      .rise_en_i     (rise_en_i),
      .fall_en_i     (fall_en_i),
      .irq_clr_i     (irq_clr_i),
      .irq_pending_o (irq_pending_o),
      .irq_o         (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sel = '0; m_out = '0; m_oe = '0; m_f = '0; m_fd = '0; m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < SS; i++) m_hist[i] = '0;
      for (int k = 0; k < NP; k++) m_run[k] = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [NP-1:0] s, n_out, n_oe, rise, fall;
      int            lim;
      s = m_hist[SS-1];
      for (int k = 0; k < NP; k++) begin
         if (ps_sel_i[k] !== m_sel[k]) begin
            n_out[k] = 1'b0; n_oe[k] = 1'b0;
         end else if (m_sel[k]) begin
            n_out[k] = ps_out_i[k]; n_oe[k] = ps_oe_i[k];
         end else begin
            n_out[k] = mcu_out_i[k]; n_oe[k] = mcu_oe_i[k];
         end
      end
      rise   = m_f & ~m_fd & rise_en_i;
      fall   = ~m_f & m_fd & fall_en_i;
      m_irq  = (m_pend != '0);
      m_pend = (m_pend & ~irq_clr_i) | rise | fall;
      m_fd   = m_f;
      // Filtered level follows the synchronised input once it has differed
      // for max(thresh,1) consecutive cycles.
      lim = (int'(deb_thresh_i) == 0) ? 1 : int'(deb_thresh_i);
      for (int k = 0; k < NP; k++) begin
         if (s[k] != m_f[k]) begin
            m_run[k]++;
            if (m_run[k] >= lim) begin
               m_f[k]   = s[k];
               m_run[k] = 0;
            end
         end else begin
            m_run[k] = 0;
         end
      end
      for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad_in_i;
      m_sel = ps_sel_i;
      m_out = n_out;
      m_oe  = n_oe;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
      check("pad_out", 64'(pad_out_o), 64'(m_out));
      check("pad_oe", 64'(pad_oe_o), 64'(m_oe));
      check("mcu_in", 64'(mcu_in_o), 64'(m_f));
      check("ps_in", 64'(ps_in_o), 64'(m_f));
      check("pending", 64'(irq_pending_o), 64'(m_pend));
      check("irq", 64'(irq_o), 64'(m_irq));
   endtask

   // Ticks until mcu_in_o[pin] reaches val; returns the count (40 = timeout).
   task automatic measure(input int pin, input logic val, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (mcu_in_o[pin] === val) break;
      end
   endtask

   initial begin
      int   n, tp, ti;
      logic seen;

      // 1: reset with all inputs high
      ps_sel_i = '1; ps_out_i = '1; ps_oe_i = '1; mcu_out_i = '1; mcu_oe_i = '1;
      pad_in_i = '1; rise_en_i = '1; fall_en_i = '1; irq_clr_i = '1; deb_thresh_i = '1;
      model_reset();
      #22;
      check("rst_pad_out", 64'(pad_out_o), 64'(0));
      check("rst_pad_oe", 64'(pad_oe_o), 64'(0));
      check("rst_mcu_in", 64'(mcu_in_o), 64'(0));
      check("rst_ps_in", 64'(ps_in_o), 64'(0));
      check("rst_pending", 64'(irq_pending_o), 64'(0));
      check("rst_irq", 64'(irq_o), 64'(0));
      @(posedge clk_i); #1;
      ps_sel_i = '0; ps_out_i = '0; ps_oe_i = '0; mcu_out_i = '0; mcu_oe_i = '0;
      pad_in_i = '0; rise_en_i = '0; fall_en_i = '0; irq_clr_i = '0; deb_thresh_i = '0;
      mcu_oe_i[3] = 1'b1; mcu_out_i[3] = 1'b1;
      rst_i = 1'b0;
      tick();
      check("t1_oe3", 64'(pad_oe_o[3]), 64'(1));
      check("t1_out3", 64'(pad_out_o[3]), 64'(1));

      // 2: ownership turnaround on pin 5
      ps_oe_i[5] = 1'b1; ps_out_i[5] = 1'b1; mcu_oe_i[5] = 1'b1; mcu_out_i[5] = 1'b0;
      tick();
      check("t2_mcu_oe", 64'(pad_oe_o[5]), 64'(1));
      check("t2_mcu_out", 64'(pad_out_o[5]), 64'(0));
      ps_sel_i[5] = 1'b1;
      tick();
      check("t2_ta_oe", 64'(pad_oe_o[5]), 64'(0));
      tick();
      check("t2_ps_oe", 64'(pad_oe_o[5]), 64'(1));
      check("t2_ps_out", 64'(pad_out_o[5]), 64'(1));
      ps_sel_i[5] = 1'b0;
      tick();
      check("t2_back_ta", 64'(pad_oe_o[5]), 64'(0));
      tick();
      check("t2_back_oe", 64'(pad_oe_o[5]), 64'(1));
      ps_sel_i[5] = 1'b1;
      tick();
      check("t2_dbl_ta1", 64'(pad_oe_o[5]), 64'(0));
      ps_sel_i[5] = 1'b0;
      tick();
      check("t2_dbl_ta2", 64'(pad_oe_o[5]), 64'(0));
      check("t2_dbl_out2", 64'(pad_out_o[5]), 64'(0));
      tick();
      check("t2_dbl_oe", 64'(pad_oe_o[5]), 64'(1));
      check("t2_dbl_out", 64'(pad_out_o[5]), 64'(0));

      // 3: unfiltered input latency
      deb_thresh_i = 8'd1;
      pad_in_i[0] = 1'b1;
      measure(0, 1'b1, n);
      check("t3_rise_lat", 64'(n), 64'(3));
      check("t3_ps_in", 64'(ps_in_o[0]), 64'(1));
      deb_thresh_i = 8'd0;
      pad_in_i[0] = 1'b0;
      measure(0, 1'b0, n);
      check("t3_fall_lat", 64'(n), 64'(3));

      // 4: glitch rejection and filtered latency on pin 7
      deb_thresh_i = 8'd10;
      pad_in_i[7] = 1'b1;
      repeat (9) tick();
      pad_in_i[7] = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         tick();
         seen = seen | mcu_in_o[7];
      end
      check("t4_glitch", 64'(seen), 64'(0));
      pad_in_i[7] = 1'b1;
      measure(7, 1'b1, n);
      check("t4_rise_lat", 64'(n), 64'(12));
      pad_in_i[7] = 1'b0;
      measure(7, 1'b0, n);
      check("t4_fall_lat", 64'(n), 64'(12));

      // 5: rising-only interrupt on pin 2
      deb_thresh_i = 8'd0;
      rise_en_i[2] = 1'b1;
      pad_in_i[2] = 1'b1;
      tp = -1; ti = -1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (tp < 0 && irq_pending_o[2] === 1'b1) tp = i;
         if (ti < 0 && irq_o === 1'b1) ti = i;
         if (i == 4) pad_in_i[2] = 1'b0;
      end
      check("t5_pend_lat", 64'(tp), 64'(4));
      check("t5_irq_lat", 64'(ti), 64'(5));
      irq_clr_i[2] = 1'b1;
      tick();
      irq_clr_i[2] = 1'b0;
      check("t5_clr", 64'(irq_pending_o[2]), 64'(0));
      repeat (3) tick();
      check("t5_no_fall", 64'(irq_pending_o[2]), 64'(0));
      check("t5_irq_low", 64'(irq_o), 64'(0));
      pad_in_i[2] = 1'b1;
      measure(2, 1'b1, n);
      check("t5_pre_coinc", 64'(irq_pending_o[2]), 64'(0));
      irq_clr_i[2] = 1'b1;
      tick();
      irq_clr_i[2] = 1'b0;
      check("t5_coinc", 64'(irq_pending_o[2]), 64'(1));

      // 6: asynchronous reset mid-turnaround and mid-debounce
      deb_thresh_i = 8'd10;
      pad_in_i[7] = 1'b1;
      repeat (6) tick();
      ps_sel_i[5] = 1'b1;
      tick();
      check("t6_in_ta", 64'(pad_oe_o[5]), 64'(0));
      #3;
      rst_i = 1'b1;
      #1;
      model_reset();
      check("t6_pad_out", 64'(pad_out_o), 64'(0));
      check("t6_pad_oe", 64'(pad_oe_o), 64'(0));
      check("t6_mcu_in", 64'(mcu_in_o), 64'(0));
      check("t6_pending", 64'(irq_pending_o), 64'(0));
      check("t6_irq", 64'(irq_o), 64'(0));
      ps_sel_i[5] = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      tick();
      check("t6_mcu_owner_oe", 64'(pad_oe_o[5]), 64'(1));
      check("t6_mcu_owner_out", 64'(pad_out_o[5]), 64'(0));
      measure(7, 1'b1, n);
      check("t6_deb_restart", 64'(n + 1), 64'(12));

      // Randomized traffic against the model
      rise_en_i = $urandom;
      fall_en_i = $urandom;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) ps_sel_i = ps_sel_i ^ ($urandom & $urandom & $urandom);
         ps_out_i  = $urandom;
         ps_oe_i   = $urandom;
         mcu_out_i = $urandom;
         mcu_oe_i  = $urandom;
         pad_in_i  = pad_in_i ^ ($urandom & $urandom & $urandom);
         irq_clr_i = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 31) == 0) deb_thresh_i = deb_cnt_t'($urandom_range(0, 5));
         if ($urandom_range(0, 63) == 0) begin
            rise_en_i = $urandom;
            fall_en_i = $urandom;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
